// File: rtl/pool2d_frame_buffer_if.sv
// Valid/ready stream carrying NUM_ELEMS elements of DATA_WIDTH bits per beat.
// The master drives data/valid and the slave drives ready.
interface pool2d_frame_buffer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_ELEMS  = 1
);
   logic [DATA_WIDTH-1:0] data [NUM_ELEMS];
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/pool2d_frame_buffer.sv
// Stream-to-frame deserializer that assembles a raster pixel stream into one parallel frame beat.
// Define POOL_FRAME_BUF_DOUBLE_EN to build the two-bank ping-pong variant; the default is single-buffered.
module pool2d_frame_buffer #(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_PRECISION_1       = 3,
   parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
   parameter int FRAME_WIDTH                 = 8,
   parameter int FRAME_HEIGHT                = 8
) (
   input logic                   clk,
   input logic                   rst,
   pool2d_frame_buffer_if.slave  data_in_0,
   pool2d_frame_buffer_if.master data_out_0
);
   localparam int PAR   = DATA_IN_0_PARALLELISM_DIM_0;
   localparam int FRAME = FRAME_WIDTH * FRAME_HEIGHT;
   localparam int BEATS = FRAME / PAR;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int DW    = DATA_IN_0_PRECISION_0;

   if (FRAME % PAR != 0) begin : g_par_check
      $error("pool2d_frame_buffer: FRAME_WIDTH*FRAME_HEIGHT must be divisible by DATA_IN_0_PARALLELISM_DIM_0");
   end
   if (DATA_IN_0_PRECISION_1 > DATA_IN_0_PRECISION_0) begin : g_frac_check
      $error("pool2d_frame_buffer: fractional bits exceed element width");
   end

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             in_ready;
   logic             out_valid;
   logic             in_fire;
   logic             out_fire;
   logic             last_beat;

   assign in_fire          = data_in_0.valid & in_ready;
   assign out_fire         = out_valid & data_out_0.ready;
   assign last_beat        = (cnt_q == CNT_W'(BEATS - 1));
   assign data_in_0.ready  = in_ready;
   assign data_out_0.valid = out_valid;

   // Beat counter wraps to zero on the beat that completes a frame.
   always_comb begin
      cnt_d = cnt_q;
      if (in_fire) begin
         cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      end
   end

`ifdef POOL_FRAME_BUF_DOUBLE_EN

   logic [DW-1:0] bank_q [2][FRAME];
   logic [DW-1:0] bank_d [2][FRAME];
   logic          wr_bank_q;
   logic          wr_bank_d;
   logic          rd_bank_q;
   logic          rd_bank_d;
   logic [1:0]    full_q;
   logic [1:0]    full_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         full_q    <= '0;
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < FRAME; i++) begin
               bank_q[b][i] <= '0;
            end
         end
      end else begin
         cnt_q     <= cnt_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
         bank_q    <= bank_d;
      end
   end

   // Drain and fill touch different banks, so both updates may land in one cycle.
   always_comb begin
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;
      if (out_fire) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
      if (in_fire && last_beat) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end
   end

   always_comb begin
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < FRAME; i++) begin
            bank_d[b][i] = bank_q[b][i];
            if (in_fire && (wr_bank_q == 1'(b)) && (cnt_q == CNT_W'(i / PAR))) begin
               bank_d[b][i] = data_in_0.data[i % PAR];
            end
         end
      end
   end

   always_comb begin
      in_ready  = !full_q[wr_bank_q] && !rst;
      out_valid = full_q[rd_bank_q];
      for (int i = 0; i < FRAME; i++) begin
         data_out_0.data[i] = bank_q[rd_bank_q][i];
      end
   end

`else

   typedef enum logic {S_FILL, S_PRESENT} state_e;

   state_e        state_q;
   state_e        state_d;
   logic [DW-1:0] buf_q [FRAME];
   logic [DW-1:0] buf_d [FRAME];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         for (int i = 0; i < FRAME; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:    if (in_fire && last_beat) state_d = S_PRESENT;
         S_PRESENT: if (out_fire)             state_d = S_FILL;
         default:                             state_d = S_FILL;
      endcase
   end

   // Element i of the frame arrives in beat i/PAR at lane i%PAR.
   always_comb begin
      for (int i = 0; i < FRAME; i++) begin
         buf_d[i] = buf_q[i];
         if (in_fire && (cnt_q == CNT_W'(i / PAR))) begin
            buf_d[i] = data_in_0.data[i % PAR];
         end
      end
   end

   always_comb begin
      in_ready  = (state_q == S_FILL) && !rst;
      out_valid = (state_q == S_PRESENT);
      for (int i = 0; i < FRAME; i++) begin
         data_out_0.data[i] = buf_q[i];
      end
   end

`endif

endmodule

// File: tb/tb_pool2d_frame_buffer.sv
// Bench for pool2d_frame_buffer: vector table and hand sequences on a 4x4 PAR=1 instance,
// plus a randomized 4x4 PAR=2 run against a frame-queue reference model.
module tb_pool2d_frame_buffer;
   localparam int W     = 4;
   localparam int H     = 4;
   localparam int FRAME = W * H;
   localparam int DW    = 8;
   localparam int NOF   = 0;
   localparam int RAMP  = 1;
   localparam int ZERO  = 2;

`ifdef POOL_FRAME_BUF_DOUBLE_EN
   localparam logic PRESENT_READY = 1'b1;
   localparam int   CAPACITY      = 2;
`else
   localparam logic PRESENT_READY = 1'b0;
   localparam int   CAPACITY      = 1;
`endif

   typedef logic [DW-1:0] frame_t [FRAME];

   typedef struct {
      string         name;
      logic          rst;
      logic          in_valid;
      logic [DW-1:0] in_data;
      logic          out_ready;
      logic          exp_in_ready;
      logic          exp_out_valid;
      int            frame_mode;
      int            frame_base;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   pool2d_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_ELEMS(1))     a_in  ();
   pool2d_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_ELEMS(FRAME)) a_out ();
   pool2d_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_ELEMS(2))     b_in  ();
   pool2d_frame_buffer_if #(.DATA_WIDTH(DW), .NUM_ELEMS(FRAME)) b_out ();

   pool2d_frame_buffer #(
      .DATA_IN_0_PRECISION_0(DW), .DATA_IN_0_PRECISION_1(3), .DATA_IN_0_PARALLELISM_DIM_0(1),
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H)
   ) dut_a (
      .clk(clk), .rst(rst), .data_in_0(a_in), .data_out_0(a_out)
   );

   pool2d_frame_buffer #(
      .DATA_IN_0_PRECISION_0(DW), .DATA_IN_0_PRECISION_1(3), .DATA_IN_0_PARALLELISM_DIM_0(2),
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H)
   ) dut_b (
      .clk(clk), .rst(rst), .data_in_0(b_in), .data_out_0(b_out)
   );

   vec_t vecs[$];

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkFrame(input string name, input frame_t actual, input frame_t expected);
      int first_bad;
      first_bad = -1;
      total++;
      for (int i = 0; i < FRAME; i++) begin
         if (actual[i] !== expected[i] && first_bad < 0) first_bad = i;
      end
      if (first_bad >= 0) begin
         bad++;
         $display("[TB] FAIL %s: element %0d got %0d, expected %0d",
                  name, first_bad, actual[first_bad], expected[first_bad]);
      end
   endtask

   task automatic makeFrame(input int mode, input int base, output frame_t f);
      for (int i = 0; i < FRAME; i++) begin
         f[i] = (mode == RAMP) ? DW'(base + i) : '0;
      end
   endtask

   task automatic addVec(input string name, input logic r, input logic v, input int d, input logic rdy,
                         input logic er, input logic ev, input int mode, input int base);
      vec_t e;
      e.name = name; e.rst = r; e.in_valid = v; e.in_data = DW'(d); e.out_ready = rdy;
      e.exp_in_ready = er; e.exp_out_valid = ev; e.frame_mode = mode; e.frame_base = base;
      vecs.push_back(e);
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d, input logic rdy);
      rst          = r;
      a_in.valid   = v;
      a_in.data[0] = d;
      a_out.ready  = rdy;
      #1;
   endtask

   initial begin
      frame_t f;
      frame_t part;
      frame_t exp_q[$];
      int     beat_idx;
      int     windows;
      logic   r;
      logic   exp_ready;

      rst = 1'b1;
      a_in.valid = 1'b0; a_in.data[0] = '0; a_out.ready = 1'b0;
      b_in.valid = 1'b0; b_in.data[0] = '0; b_in.data[1] = '0; b_out.ready = 1'b0;

      // Contiguous frame, then reset mid-fill, then a frame with a gap after every beat.
      for (int k = 0; k < 16; k++) addVec("asm", 0, 1, k, 1, 1, 0, NOF, 0);
      addVec("asm_present", 0, 0, 0, 1, PRESENT_READY, 1, RAMP, 0);
      addVec("asm_done",    0, 0, 0, 1, 1, 0, NOF, 0);
      for (int k = 0; k < 5; k++) addVec("rst_partial", 0, 1, 100 + k, 1, 1, 0, NOF, 0);
      addVec("rst_pulse", 1, 1, 200, 1, 0, 0, NOF, 0);
      addVec("rst_after", 0, 1, 0, 1, 1, 0, ZERO, 0);
      for (int k = 1; k < 16; k++) addVec("rst_refill", 0, 1, k, 1, 1, 0, NOF, 0);
      addVec("rst_present", 0, 0, 0, 1, PRESENT_READY, 1, RAMP, 0);
      addVec("rst_done",    0, 0, 0, 1, 1, 0, NOF, 0);
      for (int k = 0; k < 16; k++) begin
         addVec("stall", 0, 1, 32 + k, 1, 1, 0, NOF, 0);
         if (k < 15) addVec("stall_gap", 0, 0, 8'hEE, 1, 1, 0, NOF, 0);
      end
      addVec("stall_present", 0, 0, 0, 1, PRESENT_READY, 1, RAMP, 32);
      addVec("stall_done",    0, 0, 0, 1, 1, 0, NOF, 0);

      repeat (2) @(negedge clk);
      #1;
      makeFrame(ZERO, 0, f);
      checkOutput("reset.a_in_ready",  32'(a_in.ready),  0);
      checkOutput("reset.a_out_valid", 32'(a_out.valid), 0);
      checkFrame("reset.a_frame", a_out.data, f);
      checkOutput("reset.b_in_ready",  32'(b_in.ready),  0);
      checkOutput("reset.b_out_valid", 32'(b_out.valid), 0);
      checkFrame("reset.b_frame", b_out.data, f);

      for (int n = 0; n < vecs.size(); n++) begin
         @(negedge clk);
         applyStimulus(vecs[n].rst, vecs[n].in_valid, vecs[n].in_data, vecs[n].out_ready);
         checkOutput($sformatf("%s[%0d].in_ready", vecs[n].name, n), 32'(a_in.ready), 32'(vecs[n].exp_in_ready));
         checkOutput($sformatf("%s[%0d].out_valid", vecs[n].name, n), 32'(a_out.valid), 32'(vecs[n].exp_out_valid));
         if (vecs[n].frame_mode != NOF) begin
            makeFrame(vecs[n].frame_mode, vecs[n].frame_base, f);
            checkFrame($sformatf("%s[%0d].frame", vecs[n].name, n), a_out.data, f);
         end
      end

`ifdef POOL_FRAME_BUF_DOUBLE_EN
      // Two back-to-back frames with the sink always ready: input never stalls.
      windows = 0;
      for (int k = 0; k < 34; k++) begin
         @(negedge clk);
         applyStimulus(0, (k < 32), DW'(k), 1);
         if (k < 32) checkOutput("dbl_in_ready", 32'(a_in.ready), 1);
         if (a_out.valid === 1'b1) begin
            makeFrame(RAMP, 16 * windows, f);
            checkFrame($sformatf("dbl_frame%0d", windows), a_out.data, f);
            windows++;
         end
      end
      checkOutput("dbl_windows", 32'(windows), 2);
`else
      // Held frame under backpressure; beats offered meanwhile must be refused.
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         applyStimulus(0, 1, DW'(64 + k), 0);
      end
      makeFrame(RAMP, 64, f);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         applyStimulus(0, 1, 8'h55, 0);
         checkOutput("bp_hold.valid", 32'(a_out.valid), 1);
         checkOutput("bp_hold.in_ready", 32'(a_in.ready), 0);
         checkFrame("bp_hold.frame", a_out.data, f);
      end
      @(negedge clk);
      applyStimulus(0, 0, 0, 1);
      checkOutput("bp_release.valid", 32'(a_out.valid), 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0);
      checkOutput("bp_resume.valid", 32'(a_out.valid), 0);
      checkOutput("bp_resume.in_ready", 32'(a_in.ready), 1);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         applyStimulus(0, 1, DW'(80 + k), 0);
      end
      @(negedge clk);
      applyStimulus(0, 0, 0, 1);
      makeFrame(RAMP, 80, f);
      checkOutput("bp_next.valid", 32'(a_out.valid), 1);
      checkFrame("bp_next.frame", a_out.data, f);
`endif
      @(negedge clk);
      applyStimulus(0, 0, 0, 0);

      // Two elements per beat: eight beats make one frame.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         b_in.valid = 1'b1; b_in.data[0] = DW'(2 * k); b_in.data[1] = DW'(2 * k + 1); b_out.ready = 1'b1;
         #1;
         checkOutput("par_fill.in_ready", 32'(b_in.ready), 1);
         checkOutput("par_fill.valid", 32'(b_out.valid), 0);
      end
      @(negedge clk);
      b_in.valid = 1'b0;
      #1;
      makeFrame(RAMP, 0, f);
      checkOutput("par_present.valid", 32'(b_out.valid), 1);
      checkFrame("par_present.frame", b_out.data, f);
      @(negedge clk);
      #1;
      checkOutput("par_done.valid", 32'(b_out.valid), 0);

      // Random traffic: frames are queued in arrival order and must emerge whole and in order.
      beat_idx = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         r             = ($urandom_range(0, 199) == 0);
         rst           = r;
         b_in.valid    = ($urandom_range(0, 9) < 7);
         b_in.data[0]  = DW'($urandom);
         b_in.data[1]  = DW'($urandom);
         b_out.ready   = ($urandom_range(0, 9) < 6);
         #1;
         exp_ready = !r && (exp_q.size() < CAPACITY);
         checkOutput("rnd.in_ready", 32'(b_in.ready), 32'(exp_ready));
         checkOutput("rnd.out_valid", 32'(b_out.valid), 32'(exp_q.size() > 0));
         if (exp_q.size() > 0) checkFrame("rnd.frame", b_out.data, exp_q[0]);
         if (r) begin
            exp_q.delete();
            beat_idx = 0;
         end else begin
            if (b_out.ready && exp_q.size() > 0) exp_q.delete(0);
            if (b_in.valid && exp_ready) begin
               part[2 * beat_idx]     = b_in.data[0];
               part[2 * beat_idx + 1] = b_in.data[1];
               beat_idx++;
               if (beat_idx == FRAME / 2) begin
                  exp_q.push_back(part);
                  beat_idx = 0;
               end
            end
         end
      end

      @(negedge clk);
      rst = 1'b0; b_in.valid = 1'b0; b_out.ready = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
